window_buffer_nxn: RTL and testbench

- Parametrised successor of the 3x3 Sobel window buffer.
- Holds a WIN x WIN window of PIX_W-bit pixels for the convolution stage.
- Full fill: WIN*WIN streamed pixels through a valid/ready handshake.
- Shift: existing window moves one step in one of four directions; WIN new edge pixels are then streamed in.
- Sits between the pixel fetch/memory-read controller and the gradient calculator; exports window_valid so the gradient stage never consumes a partial window.

---
 rtl/window_buffer_nxn_if.sv | 64 ++++++
 rtl/window_buffer_nxn.sv | 218 +++++++++++++++++++++
 tb/tb_window_buffer_nxn.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/window_buffer_nxn_if.sv
// ---------------------------------------------------------------------------
// window_buffer_nxn_if
// Bundles the request, pixel handshake and window-result signals that the
// WIN x WIN window buffer exchanges with the fetch controller and the
// gradient stage.
//   master : the surrounding controller (issues requests and pixels, reads the window)
//   slave  : the window buffer itself
// Signals:
//   start_read   one-cycle full-fill request
//   start_shift  one-cycle shift request
//   shift_direc  shift direction (00 right, 01 left, 10 down, 11 up)
//   data_r       incoming pixel
//   pix_valid    data_r valid
//   pix_ready    buffer accepts a pixel this cycle
//   busy         buffer is filling or loading an edge
//   read_done    one-cycle pulse at the end of a full fill
//   shift_done   one-cycle pulse at the end of a shift plus edge load
//   window_valid window holds a complete, consistent set
//   window       flattened row-major window, element 0 in the low bits
// ---------------------------------------------------------------------------
interface window_buffer_nxn_if #(
    parameter int PIX_W = 8,
    parameter int WIN   = 3
);
    logic                       start_read;
    logic                       start_shift;
    logic [1:0]                 shift_direc;
    logic [PIX_W-1:0]           data_r;
    logic                       pix_valid;
    logic                       pix_ready;
    logic                       busy;
    logic                       read_done;
    logic                       shift_done;
    logic                       window_valid;
    logic [WIN*WIN*PIX_W-1:0]   window;

    modport master (
        output start_read,
        output start_shift,
        output shift_direc,
        output data_r,
        output pix_valid,
        input  pix_ready,
        input  busy,
        input  read_done,
        input  shift_done,
        input  window_valid,
        input  window
    );

    modport slave (
        input  start_read,
        input  start_shift,
        input  shift_direc,
        input  data_r,
        input  pix_valid,
        output pix_ready,
        output busy,
        output read_done,
        output shift_done,
        output window_valid,
        output window
    );
endinterface

// File: rtl/window_buffer_nxn.sv
// ---------------------------------------------------------------------------
// window_buffer_nxn
// Holds a WIN x WIN window of PIX_W-bit pixels for the convolution stage.
// A full fill streams WIN*WIN pixels in row-major order. A shift moves the
// existing window one step (right/left/down/up) and then streams in the WIN
// pixels of the vacated edge line. window_valid is only raised when the
// window is complete and consistent, so the gradient stage never sees a
// partially loaded window.
// Ports:
//   clk    rising-edge system clock
//   n_rst  asynchronous active-low reset
//   bus    window_buffer_nxn_if.slave (requests, pixel handshake, results)
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module window_buffer_nxn #(
    parameter int PIX_W = 8,
    parameter int WIN   = 3
) (
    input  logic                clk,
    input  logic                n_rst,
    window_buffer_nxn_if.slave  bus
);

    localparam int NPIX = WIN * WIN;
    localparam int CW   = (NPIX > 1) ? $clog2(NPIX) : 1;

    localparam logic [CW-1:0] LAST_FILL = CW'(NPIX - 1);
    localparam logic [CW-1:0] LAST_EDGE = CW'(WIN - 1);

    localparam logic [1:0] DIR_RIGHT = 2'b00;
    localparam logic [1:0] DIR_LEFT  = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_UP    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_FILL = 2'b01,
        ST_EDGE = 2'b10
    } state_t;

    state_t             state_q,      state_d;
    logic [CW-1:0]      cnt_q,        cnt_d;
    logic [1:0]         dir_q,        dir_d;
    logic [PIX_W-1:0]   win_q [NPIX];
    logic [PIX_W-1:0]   win_d [NPIX];
    logic               valid_q,      valid_d;
    logic               read_done_q,  read_done_d;
    logic               shift_done_q, shift_done_d;
    logic               busy_q,       busy_d;
    logic               pix_ready_q,  pix_ready_d;
    logic               accept_s;

    // Element index that a pixel moves in from when shifting in direction dir.
    // Positions on the vacated edge have no source and keep their stale value
    // (they are overwritten during the edge load).
    function automatic int shift_src(input logic [1:0] dir, input int r, input int c);
        int src;
        src = r * WIN + c;
        case (dir)
            DIR_RIGHT: if (c < WIN - 1) src = r * WIN + c + 1;   else src = r * WIN + c;
            DIR_LEFT:  if (c > 0)       src = r * WIN + c - 1;   else src = r * WIN + c;
            DIR_DOWN:  if (r < WIN - 1) src = (r + 1) * WIN + c; else src = r * WIN + c;
            DIR_UP:    if (r > 0)       src = (r - 1) * WIN + c; else src = r * WIN + c;
            default:   src = r * WIN + c;
        endcase
        return src;
    endfunction

    // Element written by the i-th edge pixel: column edges are loaded
    // top-to-bottom, row edges left-to-right.
    function automatic int edge_index(input logic [1:0] dir, input int i);
        int idx;
        case (dir)
            DIR_RIGHT: idx = i * WIN + (WIN - 1);
            DIR_LEFT:  idx = i * WIN;
            DIR_DOWN:  idx = (WIN - 1) * WIN + i;
            DIR_UP:    idx = i;
            default:   idx = i;
        endcase
        return idx;
    endfunction

    // pix_ready is registered, so an acceptance is simply ready & valid.
    assign accept_s = pix_ready_q & bus.pix_valid;

    // Next-state, window update and pulse generation.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        dir_d        = dir_q;
        valid_d      = valid_q;
        read_done_d  = 1'b0;
        shift_done_d = 1'b0;
        for (int k = 0; k < NPIX; k++) begin
            win_d[k] = win_q[k];
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.start_read) begin
                    // A fill request takes priority; a simultaneous shift is dropped.
                    state_d = ST_FILL;
                    cnt_d   = {CW{1'b0}};
                    valid_d = 1'b0;
                end else if (bus.start_shift && valid_q) begin
                    state_d = ST_EDGE;
                    cnt_d   = {CW{1'b0}};
                    valid_d = 1'b0;
                    dir_d   = bus.shift_direc;
                    for (int r = 0; r < WIN; r++) begin
                        for (int c = 0; c < WIN; c++) begin
                            win_d[r * WIN + c] = win_q[shift_src(bus.shift_direc, r, c)];
                        end
                    end
                end else begin
                    // Shift on an invalid window and idle pixels are ignored.
                    state_d = ST_IDLE;
                end
            end

            ST_FILL: begin
                if (accept_s) begin
                    for (int k = 0; k < NPIX; k++) begin
                        if (k == int'(cnt_q)) begin
                            win_d[k] = bus.data_r;
                        end else begin
                            win_d[k] = win_q[k];
                        end
                    end
                    if (cnt_q == LAST_FILL) begin
                        state_d     = ST_IDLE;
                        cnt_d       = {CW{1'b0}};
                        valid_d     = 1'b1;
                        read_done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    // Stall: hold state and counter.
                    cnt_d = cnt_q;
                end
            end

            ST_EDGE: begin
                if (accept_s) begin
                    for (int k = 0; k < NPIX; k++) begin
                        if (k == edge_index(dir_q, int'(cnt_q))) begin
                            win_d[k] = bus.data_r;
                        end else begin
                            win_d[k] = win_q[k];
                        end
                    end
                    if (cnt_q == LAST_EDGE) begin
                        state_d      = ST_IDLE;
                        cnt_d        = {CW{1'b0}};
                        valid_d      = 1'b1;
                        shift_done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CW{1'b0}};
                valid_d = 1'b0;
            end
        endcase

        // busy and pix_ready reflect the state being entered so they are
        // already correct in the first FILL/EDGE cycle.
        busy_d      = (state_d != ST_IDLE);
        pix_ready_d = (state_d != ST_IDLE);
    end

    // State, window and output registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= {CW{1'b0}};
            dir_q        <= 2'b00;
            valid_q      <= 1'b0;
            read_done_q  <= 1'b0;
            shift_done_q <= 1'b0;
            busy_q       <= 1'b0;
            pix_ready_q  <= 1'b0;
            for (int k = 0; k < NPIX; k++) begin
                win_q[k] <= {PIX_W{1'b0}};
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dir_q        <= dir_d;
            valid_q      <= valid_d;
            read_done_q  <= read_done_d;
            shift_done_q <= shift_done_d;
            busy_q       <= busy_d;
            pix_ready_q  <= pix_ready_d;
            for (int k = 0; k < NPIX; k++) begin
                win_q[k] <= win_d[k];
            end
        end
    end

    assign bus.pix_ready    = pix_ready_q;
    assign bus.busy         = busy_q;
    assign bus.read_done    = read_done_q;
    assign bus.shift_done   = shift_done_q;
    assign bus.window_valid = valid_q;

    for (genvar g = 0; g < NPIX; g++) begin : g_window_out
        assign bus.window[g * PIX_W +: PIX_W] = win_q[g];
    end

endmodule

// File: tb/tb_window_buffer_nxn.sv
// ---------------------------------------------------------------------------
// tb_window_buffer_nxn
// Self-checking bench for window_buffer_nxn (PIX_W=8, WIN=3). A behavioural
// model keeps the window as a 2-D grid and applies fills and shifts by row /
// column coordinates; every scenario task compares the DUT against it.
// ---------------------------------------------------------------------------
module tb_window_buffer_nxn;

    localparam int PW = 8;
    localparam int W  = 3;
    localparam int NP = W * W;

    logic clk;
    logic n_rst;

    window_buffer_nxn_if #(.PIX_W(PW), .WIN(W)) bus ();

    window_buffer_nxn #(.PIX_W(PW), .WIN(W)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [PW-1:0] stim  [NP];
    logic [PW-1:0] m_win [NP];
    bit            m_valid;

    // Observations from the last operation
    int rd_p, sh_p, done_c, last_c, busy_c;
    bit valid_bad, timed_out;

    function automatic logic [NP*PW-1:0] model_flat();
        logic [NP*PW-1:0] f;
        for (int k = 0; k < NP; k++) f[k*PW +: PW] = m_win[k];
        return f;
    endfunction

    task automatic model_fill();
        for (int k = 0; k < NP; k++) m_win[k] = stim[k];
        m_valid = 1'b1;
    endtask

    // Shift on a 2-D grid, then load the vacated line from stim[0..W-1].
    task automatic model_shift(input logic [1:0] dir);
        logic [PW-1:0] o [W][W];
        logic [PW-1:0] g [W][W];
        for (int r = 0; r < W; r++)
            for (int c = 0; c < W; c++) begin
                o[r][c] = m_win[r*W + c];
                g[r][c] = o[r][c];
            end
        case (dir)
            2'b00: begin
                for (int r = 0; r < W; r++) for (int c = 0; c < W-1; c++) g[r][c] = o[r][c+1];
                for (int i = 0; i < W; i++) g[i][W-1] = stim[i];
            end
            2'b01: begin
                for (int r = 0; r < W; r++) for (int c = 1; c < W; c++) g[r][c] = o[r][c-1];
                for (int i = 0; i < W; i++) g[i][0] = stim[i];
            end
            2'b10: begin
                for (int r = 0; r < W-1; r++) for (int c = 0; c < W; c++) g[r][c] = o[r+1][c];
                for (int i = 0; i < W; i++) g[W-1][i] = stim[i];
            end
            default: begin
                for (int r = 1; r < W; r++) for (int c = 0; c < W; c++) g[r][c] = o[r-1][c];
                for (int i = 0; i < W; i++) g[0][i] = stim[i];
            end
        endcase
        for (int r = 0; r < W; r++)
            for (int c = 0; c < W; c++) m_win[r*W + c] = g[r][c];
        m_valid = 1'b1;
    endtask

    // Drives one request and streams n_exp pixels from stim. stall_pct < 0
    // means pix_valid alternates (low in odd cycles); otherwise it is the
    // percentage of cycles with pix_valid low. noise pulses both start inputs
    // in cycle 2 while busy. Cycle 0 is the cycle carrying the start pulse.
    task automatic run_op(input bit rd, input bit sh, input logic [1:0] dir,
                          input int stall_pct, input int n_exp, input bit noise);
        int idx, cyc;
        bit acc;
        idx = 0; cyc = 0; acc = 1'b0;
        rd_p = 0; sh_p = 0; done_c = -1; last_c = -1; busy_c = 0;
        valid_bad = 1'b0; timed_out = 1'b0;
        bus.start_read  = rd;
        bus.start_shift = sh;
        bus.shift_direc = dir;
        bus.pix_valid   = 1'b0;
        while (1) begin
            @(posedge clk); #1;
            cyc++;
            if (acc) begin idx++; last_c = cyc - 1; end
            if (bus.read_done)  begin rd_p++; done_c = cyc; end
            if (bus.shift_done) begin sh_p++; done_c = cyc; end
            if (bus.busy) busy_c++;
            if (bus.busy && bus.window_valid) valid_bad = 1'b1;
            bus.start_read  = 1'b0;
            bus.start_shift = 1'b0;
            if (noise && cyc == 2 && bus.busy) begin
                bus.start_read  = 1'b1;
                bus.start_shift = 1'b1;
            end
            if (idx >= n_exp && cyc >= last_c + 4 && cyc >= 4) break;
            if (cyc > 600) begin timed_out = 1'b1; break; end
            if (idx < n_exp) begin
                if (stall_pct < 0) bus.pix_valid = (cyc % 2 == 0);
                else               bus.pix_valid = ($urandom_range(99) >= stall_pct);
                bus.data_r = stim[idx];
            end else begin
                bus.pix_valid = 1'b0;
            end
            acc = bus.pix_valid && bus.pix_ready;
        end
        bus.pix_valid   = 1'b0;
        bus.start_read  = 1'b0;
        bus.start_shift = 1'b0;
    endtask

    task automatic stim_ramp(input int base, input int n);
        for (int k = 0; k < n; k++) stim[k] = PW'(base + k);
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        bus.start_read = 1'b0; bus.start_shift = 1'b0; bus.shift_direc = 2'b00;
        bus.pix_valid = 1'b0; bus.data_r = '0;
        for (int k = 0; k < NP; k++) m_win[k] = '0;
        m_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({bus.busy, bus.pix_ready, bus.read_done, bus.shift_done, bus.window_valid} !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 00000",
                     {bus.busy, bus.pix_ready, bus.read_done, bus.shift_done, bus.window_valid});
        end
        n_rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (bus.window !== model_flat()) begin
            n_fail++; $display("FAIL reset_window: got %h want %h", bus.window, model_flat());
        end
    endtask

    task automatic test_shift_without_window();
        stim_ramp(100, W);
        run_op(1'b0, 1'b1, 2'b00, 0, 0, 1'b0);
        n_checks++;
        if (sh_p !== 0 || busy_c !== 0) begin
            n_fail++; $display("FAIL shift_no_window: shift_done pulses %0d busy cycles %0d, want 0 0", sh_p, busy_c);
        end
        // Pixels offered in IDLE must be refused and must not touch the window.
        bus.pix_valid = 1'b1; bus.data_r = 8'hAA;
        repeat (3) begin
            @(posedge clk); #1;
            n_checks++;
            if (bus.pix_ready !== 1'b0) begin
                n_fail++; $display("FAIL idle_ready: got %b want 0", bus.pix_ready);
            end
        end
        bus.pix_valid = 1'b0;
        n_checks++;
        if (bus.window !== model_flat()) begin
            n_fail++; $display("FAIL idle_window: got %h want %h", bus.window, model_flat());
        end
    endtask

    task automatic test_fill(input int stall, input int want_done, input string name);
        stim_ramp(0, NP);
        run_op(1'b1, 1'b0, 2'b00, stall, NP, 1'b0);
        model_fill();
        n_checks++;
        if (timed_out || rd_p !== 1 || sh_p !== 0) begin
            n_fail++; $display("FAIL %s_pulses: read_done %0d shift_done %0d timeout %0d, want 1 0 0", name, rd_p, sh_p, timed_out);
        end
        n_checks++;
        if (done_c !== want_done) begin
            n_fail++; $display("FAIL %s_latency: read_done in cycle %0d want %0d", name, done_c, want_done);
        end
        n_checks++;
        if (bus.window !== model_flat() || bus.window_valid !== 1'b1) begin
            n_fail++; $display("FAIL %s_window: got %h valid %b want %h valid 1", name, bus.window, bus.window_valid, model_flat());
        end
        n_checks++;
        if (valid_bad || busy_c !== last_c) begin
            n_fail++; $display("FAIL %s_busy: valid_while_busy %0d busy cycles %0d want 0 %0d", name, valid_bad, busy_c, last_c);
        end
    endtask

    task automatic test_shift(input logic [1:0] dir, input int base, input logic [NP*PW-1:0] want, input string name);
        stim_ramp(0, NP);
        run_op(1'b1, 1'b0, 2'b00, 0, NP, 1'b0);
        model_fill();
        stim_ramp(base, W);
        run_op(1'b0, 1'b1, dir, 0, W, 1'b0);
        model_shift(dir);
        n_checks++;
        if (timed_out || sh_p !== 1 || rd_p !== 0 || done_c !== W + 1) begin
            n_fail++; $display("FAIL %s_pulses: shift_done %0d read_done %0d in cycle %0d, want 1 0 in cycle %0d", name, sh_p, rd_p, done_c, W + 1);
        end
        n_checks++;
        if (bus.window !== want || bus.window !== model_flat()) begin
            n_fail++; $display("FAIL %s_window: got %h want %h", name, bus.window, want);
        end
        n_checks++;
        if (valid_bad || bus.window_valid !== 1'b1) begin
            n_fail++; $display("FAIL %s_valid: valid_while_busy %0d final valid %b, want 0 1", name, valid_bad, bus.window_valid);
        end
    endtask

    task automatic test_read_and_shift();
        stim_ramp(60, NP);
        run_op(1'b1, 1'b1, 2'b00, 0, NP, 1'b0);
        model_fill();
        n_checks++;
        if (rd_p !== 1 || sh_p !== 0 || bus.window !== model_flat()) begin
            n_fail++; $display("FAIL read_and_shift: read_done %0d shift_done %0d window %h, want 1 0 %h", rd_p, sh_p, bus.window, model_flat());
        end
    endtask

    task automatic test_reset_abort();
        int acc_n, dones;
        stim_ramp(70, NP);
        acc_n = 0; dones = 0;
        bus.start_read = 1'b1;
        @(posedge clk); #1;
        bus.start_read = 1'b0;
        for (int cyc = 0; cyc < 50 && acc_n < 4; cyc++) begin
            bus.pix_valid = 1'b1; bus.data_r = stim[acc_n];
            if (bus.pix_ready) acc_n++;
            @(posedge clk); #1;
        end
        bus.pix_valid = 1'b0;
        n_rst = 1'b0;
        #2;
        for (int k = 0; k < NP; k++) m_win[k] = '0;
        m_valid = 1'b0;
        n_checks++;
        if (acc_n !== 4 || bus.window !== model_flat() || bus.busy !== 1'b0 || bus.read_done !== 1'b0) begin
            n_fail++; $display("FAIL reset_abort: accepted %0d window %h busy %b read_done %b, want 4 %h 0 0", acc_n, bus.window, bus.busy, bus.read_done, model_flat());
        end
        @(posedge clk); #1;
        n_rst = 1'b1;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.read_done || bus.busy) dones++;
        end
        n_checks++;
        if (dones !== 0 || bus.window_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_abort_after: activity cycles %0d valid %b, want 0 0", dones, bus.window_valid);
        end
    endtask

    task automatic test_random();
        bit rd, sh, was_valid;
        logic [1:0] dir;
        int stall, n_exp;
        for (int t = 0; t < 40; t++) begin
            rd  = ($urandom_range(99) < 30);
            sh  = ($urandom_range(99) < 75);
            dir = 2'($urandom_range(3));
            stall = $urandom_range(60);
            for (int k = 0; k < NP; k++) stim[k] = PW'($urandom);
            was_valid = m_valid;
            n_exp = rd ? NP : ((sh && was_valid) ? W : 0);
            run_op(rd, sh, dir, stall, n_exp, ($urandom_range(1) == 1));
            if (rd) model_fill();
            else if (sh && was_valid) model_shift(dir);
            n_checks++;
            if (timed_out || rd_p !== (rd ? 1 : 0) || sh_p !== ((!rd && sh && was_valid) ? 1 : 0)) begin
                n_fail++; $display("FAIL rand_pulses[%0d]: read_done %0d shift_done %0d timeout %0d", t, rd_p, sh_p, timed_out);
            end
            n_checks++;
            if (bus.window !== model_flat() || bus.window_valid !== m_valid) begin
                n_fail++; $display("FAIL rand_window[%0d]: got %h valid %b want %h valid %b", t, bus.window, bus.window_valid, model_flat(), m_valid);
            end
            if (n_exp > 0) begin
                n_checks++;
                if (done_c !== last_c + 1 || busy_c !== last_c || valid_bad) begin
                    n_fail++; $display("FAIL rand_timing[%0d]: done cycle %0d busy %0d valid_bad %0d, want %0d %0d 0", t, done_c, busy_c, valid_bad, last_c + 1, last_c);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_shift_without_window();
        test_fill(0, NP + 1, "fill");
        test_fill(-1, 19, "stalled_fill");
        test_shift(2'b00, 20, {8'd22, 8'd8, 8'd7, 8'd21, 8'd5, 8'd4, 8'd20, 8'd2, 8'd1}, "shift_right");
        test_shift(2'b11, 30, {8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0, 8'd32, 8'd31, 8'd30}, "shift_up");
        test_shift(2'b10, 40, {8'd42, 8'd41, 8'd40, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3}, "shift_down");
        test_shift(2'b01, 50, {8'd7, 8'd6, 8'd52, 8'd4, 8'd3, 8'd51, 8'd1, 8'd0, 8'd50}, "shift_left");
        test_read_and_shift();
        test_reset_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
